// File: rtl/riscv_pkg.sv
// Shared core types and constants for the integer register file.
package riscv_pkg;

  localparam int unsigned RF_ADDR_W = 5;
  localparam int unsigned RF_WIDTH  = 32;

  typedef logic [RF_ADDR_W-1:0] reg_addr_t;
  typedef logic [RF_WIDTH-1:0]  xlen_t;

  // Index of the hardwired-zero register.
  localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: zero-register check, optional write forwarding, array select.
module rf_read_port
  import riscv_pkg::*;
#(
  parameter int unsigned WIDTH  = RF_WIDTH,
  parameter int unsigned ADDR_W = RF_ADDR_W,
  parameter int unsigned BYPASS = 1
) (
  input  logic [WIDTH-1:0]  regs_i [2**ADDR_W],
  input  logic [ADDR_W-1:0] raddr_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  output logic [WIDTH-1:0]  rdata_o
);

  // Register 0 always reads zero; forwarding only applies to real registers.
  always_comb begin
    rdata_o = '0;
    if (raddr_i == ADDR_W'(REG_ZERO)) begin
      rdata_o = '0;
    end else if ((BYPASS != 0) && we_i && (waddr_i == raddr_i)) begin
      rdata_o = wdata_i;
    end else begin
      rdata_o = regs_i[raddr_i];
    end
  end

endmodule

// File: rtl/reg_file.sv
// Integer register file: 2**ADDR_W x WIDTH, two combinational reads, one synchronous write.
module reg_file
  import riscv_pkg::*;
#(
  parameter int unsigned WIDTH  = RF_WIDTH,
  parameter int unsigned ADDR_W = RF_ADDR_W,
  parameter int unsigned BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [WIDTH-1:0]  rdata1,
  output logic [WIDTH-1:0]  rdata2
);

  localparam int unsigned Depth = 2**ADDR_W;

  logic [WIDTH-1:0] regs_q [Depth];
  logic             we_fwd;

  // Entry 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < Depth; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we && (waddr != ADDR_W'(REG_ZERO))) begin
      regs_q[waddr] <= wdata;
    end
  end

  // Suppress forwarding while in reset so both outputs read zero.
  always_comb begin
    we_fwd = we & rst_n;
  end

  rf_read_port #(
    .WIDTH  (WIDTH),
    .ADDR_W (ADDR_W),
    .BYPASS (BYPASS)
  ) u_rd1 (
    .regs_i  (regs_q),
    .raddr_i (raddr1),
    .we_i    (we_fwd),
    .waddr_i (waddr),
    .wdata_i (wdata),
    .rdata_o (rdata1)
  );

  rf_read_port #(
    .WIDTH  (WIDTH),
    .ADDR_W (ADDR_W),
    .BYPASS (BYPASS)
  ) u_rd2 (
    .regs_i  (regs_q),
    .raddr_i (raddr2),
    .we_i    (we_fwd),
    .waddr_i (waddr),
    .wdata_i (wdata),
    .rdata_o (rdata2)
  );

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file; one instance with forwarding, one without, sharing stimulus.
module tb_reg_file;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic [31:0] byp_rd1, byp_rd2;
  logic [31:0] nob_rd1, nob_rd2;

  int total = 0;
  int bad   = 0;

  reg_file #(.WIDTH(32), .ADDR_W(5), .BYPASS(1)) dut_byp (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .raddr1 (raddr1),
    .raddr2 (raddr2),
    .rdata1 (byp_rd1),
    .rdata2 (byp_rd2)
  );

  reg_file #(.WIDTH(32), .ADDR_W(5), .BYPASS(0)) dut_nob (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .raddr1 (raddr1),
    .raddr2 (raddr2),
    .rdata1 (nob_rd1),
    .rdata2 (nob_rd2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; waddr = a; wdata = d;
    step();
    we = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1; we = 1'b0; waddr = '0; wdata = '0; raddr1 = '0; raddr2 = '0;
    #2 rst_n = 1'b0;
    #10 rst_n = 1'b1;
    step();

    // Reset clears storage immediately, between clock edges
    wr(5'd5, 32'hDEADBEEF);
    raddr1 = 5'd5;
    #1;
    chk("preload_x5_byp", byp_rd1, 32'hDEADBEEF);
    chk("preload_x5_nob", nob_rd1, 32'hDEADBEEF);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_x5_byp", byp_rd1, 32'h0);
    chk("async_rst_x5_nob", nob_rd1, 32'h0);
    for (int i = 0; i < 32; i++) begin
      raddr1 = 5'(i); raddr2 = 5'(31 - i);
      #1;
      chk($sformatf("rst_all_byp1_%0d", i), byp_rd1, 32'h0);
      chk($sformatf("rst_all_nob2_%0d", i), nob_rd2, 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Basic write then read on both ports; we=0 leaves storage alone
    wr(5'd7, 32'h12345678);
    raddr1 = 5'd7; raddr2 = 5'd7;
    #1;
    chk("basic_byp1", byp_rd1, 32'h12345678);
    chk("basic_byp2", byp_rd2, 32'h12345678);
    chk("basic_nob1", nob_rd1, 32'h12345678);
    chk("basic_nob2", nob_rd2, 32'h12345678);
    waddr = 5'd7; wdata = 32'hBAD0BAD0;
    step();
    chk("we0_hold_byp", byp_rd1, 32'h12345678);
    chk("we0_hold_nob", nob_rd1, 32'h12345678);

    // x0 stays zero in the write cycle and afterwards
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; raddr1 = 5'd0; raddr2 = 5'd0;
    #1;
    chk("x0_wcyc_byp", byp_rd1, 32'h0);
    chk("x0_wcyc_nob", nob_rd1, 32'h0);
    step();
    we = 1'b0;
    #1;
    chk("x0_after_byp", byp_rd1, 32'h0);
    chk("x0_after_nob", nob_rd2, 32'h0);

    // Same-cycle write to a register read on both ports
    wr(5'd3, 32'h00000011);
    we = 1'b1; waddr = 5'd3; wdata = 32'h00000022; raddr1 = 5'd3; raddr2 = 5'd3;
    #1;
    chk("bypass_byp1", byp_rd1, 32'h22);
    chk("bypass_byp2", byp_rd2, 32'h22);
    chk("bypass_nob1", nob_rd1, 32'h11);
    chk("bypass_nob2", nob_rd2, 32'h11);
    step();
    we = 1'b0;
    #1;
    chk("bypass_next_nob1", nob_rd1, 32'h22);
    chk("bypass_next_nob2", nob_rd2, 32'h22);
    chk("bypass_next_byp1", byp_rd1, 32'h22);

    // Unrelated write must not disturb reads of other registers
    wr(5'd1, 32'hA);
    wr(5'd2, 32'hB);
    we = 1'b1; waddr = 5'd4; wdata = 32'hC; raddr1 = 5'd1; raddr2 = 5'd2;
    #1;
    chk("indep_byp1", byp_rd1, 32'hA);
    chk("indep_byp2", byp_rd2, 32'hB);
    chk("indep_nob1", nob_rd1, 32'hA);
    chk("indep_nob2", nob_rd2, 32'hB);
    raddr2 = 5'd4;
    #1;
    chk("one_port_fwd_byp2", byp_rd2, 32'hC);
    chk("one_port_fwd_nob2", nob_rd2, 32'h0);
    step();
    we = 1'b0;
    raddr1 = 5'd4;
    #1;
    chk("x4_written_nob", nob_rd1, 32'hC);

    // Reset held across a write edge: write lost, outputs zero during reset
    we = 1'b1; waddr = 5'd9; wdata = 32'h55; raddr1 = 5'd9; raddr2 = 5'd7;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_fwd_byp1", byp_rd1, 32'h0);
    chk("rst_x7_byp2", byp_rd2, 32'h0);
    step();
    rst_n = 1'b1;
    we = 1'b0;
    #1;
    chk("rst_midwr_x9_byp", byp_rd1, 32'h0);
    chk("rst_midwr_x9_nob", nob_rd1, 32'h0);
    chk("rst_midwr_x7_nob", nob_rd2, 32'h0);
    wr(5'd9, 32'h66);
    #1;
    chk("first_wr_after_rst_byp", byp_rd1, 32'h66);
    chk("first_wr_after_rst_nob", nob_rd1, 32'h66);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
